fpu_add_scheduler: RTL and testbench

- Shares one FPU_Add2 adder/subtractor between NUM_REQ requesters, such as the APB register front-end and the core coprocessor port.
- Arbitrates round-robin, latches the winning operands, and issues a one-cycle add or sub command to the adder.
- Waits for the adder's registered valid, then returns the result to the winner with a valid/ready handshake.
- A watchdog guards against a missing valid.

---
 rtl/fpu_sched_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/fpu_add_scheduler.sv | 138 +++++++++++++
 tb/tb_fpu_add_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared types for the apb_fpu operation schedulers: FSM states and the latched
// adder command.
package fpu_sched_pkg;
  localparam int FP_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [FP_W-1:0] op1;
    logic [FP_W-1:0] op2;
    logic            sub;
  } fpu_cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping. Shared by the add/mul/div schedulers.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx
);
  function automatic int slot(input logic [ID_W-1:0] p, input int k);
    return (int'(p) + k) % N;
  endfunction

  // Walk from the farthest slot back to ptr so the nearest requester wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (req[slot(ptr, k)]) begin
        gnt               = '0;
        gnt[slot(ptr, k)] = 1'b1;
        idx               = ID_W'(slot(ptr, k));
      end
    end
  end
endmodule

// File: rtl/fpu_add_scheduler.sv
// Time-shares one FPU adder among NUM_REQ requesters: round-robin accept,
// one-cycle command issue, watchdog-guarded wait, and a held response.
module fpu_add_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 8,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_sub,
  input  logic [NUM_REQ*32-1:0]   req_op1,
  input  logic [NUM_REQ*32-1:0]   req_op2,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic [31:0]             fpu_op1,
  output logic [31:0]             fpu_op2,
  output logic                    fpu_add_select,
  output logic                    fpu_sub_select,
  output logic                    fpu_enable,
  input  logic [31:0]             fpu_result,
  input  logic                    fpu_valid,
  output logic                    busy
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  fpu_cmd_t            cmd_q, cmd_d;
  logic                en_q, en_d;
  logic [FP_W-1:0]     rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cmd_d       = cmd_q;
    en_d        = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    wdog_d      = wdog_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (|(req_valid & gnt)) begin
          cmd_d.op1 = req_op1[int'(gnt_idx)*FP_W +: FP_W];
          cmd_d.op2 = req_op2[int'(gnt_idx)*FP_W +: FP_W];
          cmd_d.sub = req_sub[gnt_idx];
          id_d      = gnt_idx;
          en_d      = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fpu_valid) begin
          rsp_data_d  = fpu_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << id_q;
          state_d     = RESP;
        end else if (wdog_q == WD_W'(TIMEOUT-1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NUM_REQ'(1) << id_q;
          state_d     = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        // Only the owner's ready completes the response.
        if (rsp_ready[id_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cmd_q       <= '0;
      en_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cmd_q       <= cmd_d;
      en_q        <= en_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      wdog_q      <= wdog_d;
    end
  end

  assign fpu_op1        = cmd_q.op1;
  assign fpu_op2        = cmd_q.op2;
  assign fpu_enable     = en_q;
  assign fpu_add_select = en_q & ~cmd_q.sub;
  assign fpu_sub_select = en_q &  cmd_q.sub;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_fpu_add_scheduler.sv
// Randomized transaction-level bench for fpu_add_scheduler with a registered
// adder model, round-robin reference and response checks.
module tb_fpu_add_scheduler;
  localparam int N  = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_op1, req_op2;
  logic [31:0]     rsp_data, fpu_op1, fpu_op2, fpu_result;
  logic            rsp_err, fpu_add_select, fpu_sub_select, fpu_enable, fpu_valid, busy;

  int checks = 0, fails = 0;
  int ptr = 0;
  bit fpu_on = 1'b1, spur = 1'b0;
  int issues = 0;
  logic [31:0] iss_op1, iss_op2;
  logic iss_bad = 1'b0;

  fpu_add_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_add_select(fpu_add_select),
    .fpu_sub_select(fpu_sub_select), .fpu_enable(fpu_enable),
    .fpu_result(fpu_result), .fpu_valid(fpu_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Adder stand-in: exact results for the directed vectors, a cheap mix otherwise.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !s) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'h3F80_0000 &&  s) return 32'h4000_0000;
    return s ? a - b : a + b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_valid  <= 1'b0;
      fpu_result <= 32'h0;
    end else begin
      fpu_valid  <= (fpu_enable && fpu_on) || spur;
      fpu_result <= fpu_enable ? fpu_model(fpu_op1, fpu_op2, fpu_sub_select) : 32'hDEAD_BEEF;
      if (fpu_enable) begin
        issues  <= issues + 1;
        iss_op1 <= fpu_op1;
        iss_op2 <= fpu_op2;
        if (fpu_add_select == fpu_sub_select) iss_bad <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_valid[i]        = 1'b1;
    req_op1[i*32 +: 32] = a;
    req_op2[i*32 +: 32] = b;
    req_sub[i]          = s;
  endtask

  // One complete transaction: arbitrate, issue, wait, hold under backpressure, handshake.
  task automatic run_op(input logic [N-1:0] mask, input int bp, input bit to, output int w);
    logic [31:0] a, b, ed;
    logic        s;
    logic [N-1:0] oh;
    int n, lat, iss0;
    fpu_on = !to;
    for (int i = 0; i < N; i++)
      if (!mask[i]) req_valid[i] = 1'b0;
      else if (!req_valid[i]) set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    #1;
    w = 0;
    for (int k = N-1; k >= 0; k--) if (req_valid[(ptr+k)%N]) w = (ptr+k)%N;
    oh = N'(1) << w;
    a = req_op1[w*32 +: 32];
    b = req_op2[w*32 +: 32];
    s = req_sub[w];
    ed = to ? 32'h0 : fpu_model(a, b, s);
    n = 0;
    while (req_ready == '0 && n < 30) begin @(negedge clk); #1; n++; end
    chk("grant", 64'(req_ready), 64'(oh));
    iss0 = issues;
    @(negedge clk); #1;
    req_valid[w] = 1'b0;
    chk("issue_sel", 64'({fpu_enable, fpu_add_select, fpu_sub_select}), 64'({1'b1, ~s, s}));
    chk("ready_busy", 64'({req_ready, busy}), 64'({{N{1'b0}}, 1'b1}));
    lat = 1;
    while (rsp_valid == '0 && lat < TO+10) begin @(negedge clk); #1; lat++; end
    chk("latency", 64'(lat), to ? 64'(TO+2) : 64'(3));
    chk("issue_cnt", 64'(issues - iss0), 64'(1));
    chk("issue_ops", {iss_op1, iss_op2}, {a, b});
    chk("sel_excl", 64'(iss_bad), 64'(0));
    chk("rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'({oh, to, ed}));
    for (int k = 0; k < bp; k++) begin
      rsp_ready = N'($urandom) & ~oh;
      spur = 1'b1;
      @(negedge clk); #1;
      chk("bp_hold", 64'({rsp_valid, rsp_err, rsp_data, req_ready, fpu_enable}),
          64'({oh, to, ed, {N{1'b0}}, 1'b0}));
    end
    rsp_ready = oh;
    @(negedge clk); #1;
    rsp_ready = '0;
    spur = 1'b0;
    ptr = (w + 1) % N;
    chk("post_hs", 64'({rsp_valid, busy}), 64'(0));
  endtask

  initial begin
    int w, n;
    bit bad;
    rst = 1'b1; req_valid = '0; req_sub = '0; req_op1 = '0; req_op2 = '0; rsp_ready = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctl", 64'({busy, rsp_valid, rsp_err, fpu_enable, fpu_add_select, fpu_sub_select}), 64'(0));
    chk("rst_data", {rsp_data, fpu_op1}, 64'(0));
    rst = 1'b0;
    @(negedge clk); #1;
    chk("idle", 64'({busy, req_ready}), 64'(0));

    set_req(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    run_op(2'b01, 0, 1'b0, w);
    chk("add_res_w", 64'(w), 64'(0));
    set_req(1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    run_op(2'b10, 0, 1'b0, w);
    chk("sub_res_w", 64'(w), 64'(1));

    for (int k = 0; k < 8; k++) begin
      run_op(2'b11, k % 3, 1'b0, w);
      chk("rr_order", 64'(w), 64'(k % 2));
    end

    run_op(2'b01, 5, 1'b0, w);
    run_op(2'b01, 2, 1'b1, w);
    run_op(2'b11, 0, 1'b0, w);
    chk("to_ptr_adv", 64'(w), 64'(1));

    for (int k = 0; k < 24; k++)
      run_op(N'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 7) == 0, w);

    // Abort an operation in WAIT: ptr must return to 0 and no response may surface.
    run_op(2'b01, 0, 1'b0, w);
    fpu_on = 1'b0;
    req_valid = '0;
    set_req(1, $urandom, $urandom, 1'b0);
    #1;
    n = 0;
    while (req_ready == '0 && n < 30) begin @(negedge clk); #1; n++; end
    @(negedge clk); req_valid = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("mid_wait", 64'({busy, rsp_valid}), 64'({1'b1, {N{1'b0}}}));
    rst = 1'b1;
    #1;
    chk("arst_ctl", 64'({busy, rsp_valid, rsp_err, fpu_enable, req_ready}), 64'(0));
    chk("arst_data", {rsp_data, fpu_op1}, 64'(0));
    chk("arst_op2", 64'(fpu_op2), 64'(0));
    @(negedge clk); rst = 1'b0;
    ptr = 0;
    fpu_on = 1'b1;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk); #1;
      if (rsp_valid != '0 || busy) bad = 1'b1;
    end
    chk("no_stale", 64'(bad), 64'(0));
    run_op(2'b11, 1, 1'b0, w);
    chk("ptr_after_rst", 64'(w), 64'(0));
    run_op(2'b11, 0, 1'b0, w);
    chk("rr_after_rst", 64'(w), 64'(1));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
